shift_exec_stage: RTL

- Pipelined execute-stage wrapper directly upstream of and around the existing barrelshifter32. Accepts decoded shift micro-ops from issue, selects the shift amount, and drives barrelshifter32. Registers the result toward writeback.
- Uses valid/ready handshakes on both sides, supports a pipeline flush, and flags the reserved op encoding.

---
 rtl/shift_pkg.sv | 19 +
 rtl/barrelshifter32.sv | 28 ++
 rtl/shift_exec_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift execute stage: op encodings and the S1 payload.
package shift_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  // rd is carried at a fixed maximum width; the stage uses the low TAG_W bits.
  localparam int RD_W_MAX = 16;

  typedef struct packed {
    logic [1:0]          op;
    logic [31:0]         data;
    logic [4:0]          shamt;
    logic [RD_W_MAX-1:0] rd;
  } s1_pay_t;

endpackage

// File: rtl/barrelshifter32.sv
// Combinational 32-bit barrel shifter: logical left, logical right, arithmetic right.
module barrelshifter32 (
  input  logic [31:0] i,
  input  logic [4:0]  s,
  input  logic        is_left,
  input  logic        is_sra,
  output logic [31:0] o
);

  logic [5:0][31:0] stage;
  logic             fill;

  assign fill = is_sra & ~is_left & i[31];

  // Left shifts reuse the right-shift network by bit-reversing in and out.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev
      assign stage[0][gi] = is_left ? i[31-gi] : i[gi];
      assign o[gi]        = is_left ? stage[5][31-gi] : stage[5][gi];
    end
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage[gi+1] = s[gi] ? {{SH{fill}}, stage[gi][31:SH]} : stage[gi];
    end
  endgenerate

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage execute wrapper around barrelshifter32 with valid/ready on both sides,
// flush, and a saturating counter of reserved ops delivered to writeback.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int TAG_W         = 5,
  parameter int ILLEGAL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [31:0]              in_data,
  input  logic [31:0]              in_rs2,
  input  logic [4:0]               in_imm_shamt,
  input  logic                     in_use_imm,
  input  logic [TAG_W-1:0]         in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_rd,
  output logic                     out_illegal,
  output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

  s1_pay_t                  s1_q, s1_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [31:0]              result_q, result_d;
  logic [TAG_W-1:0]         rd_q, rd_d;
  logic                     illegal_q, illegal_d;
  logic [ILLEGAL_CNT_W-1:0] cnt_q, cnt_d;

  logic        s1_adv, s2_adv, in_fire, out_fire;
  logic [31:0] shift_out;

  logic unused_bits;
  assign unused_bits = ^{in_rs2[31:5], s1_q.rd};

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;
  assign out_fire = s2_valid_q && out_ready;

  barrelshifter32 u_shifter (
    .i       (s1_q.data),
    .s       (s1_q.shamt),
    .is_left (s1_q.op == OP_SLL),
    .is_sra  (s1_q.op == OP_SRA),
    .o       (shift_out)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    rd_d       = rd_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_fire) begin
        s1_d.op    = in_op;
        s1_d.data  = in_data;
        s1_d.shamt = in_use_imm ? in_imm_shamt : in_rs2[4:0];
        s1_d.rd    = RD_W_MAX'(in_rd);
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d  = (s1_q.op == OP_RSVD) ? 32'h0 : shift_out;
        rd_d      = s1_q.rd[TAG_W-1:0];
        illegal_d = (s1_q.op == OP_RSVD);
      end
    end

    // A delivery in the flush cycle still counts; flush only kills the valids.
    if (out_fire && illegal_q && (cnt_q != {ILLEGAL_CNT_W{1'b1}}))
      cnt_d = cnt_q + ILLEGAL_CNT_W'(1);

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= 32'h0;
      rd_q       <= '0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = result_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule
